multi_edge_detector: RTL and testbench
======================================

// Module: multi_edge_detector
// PURPOSE
//  Parametrised N-channel edge detector for asynchronous inputs such as buttons and sensors.
//  Per channel: synchronizer, optional debounce filter, selectable rise/fall/both detection,
//  a one-cycle pulse, a sticky event flag with clear, and a saturating event counter.
//  Sits between board I/O and the control FSMs; irq feeds the top-level controller.
// PARAMETERS
//  CH          4   number of channels (>=1)
//  SYNC_STAGES 2   synchronizer flops per channel (>=2)
//  DB_CYCLES   16  consecutive stable cycles required to accept a new level (debounce only, >=1)
//  CNT_W       8   width of each per-channel event counter (>=1)
// PORTS
//  clk     in   1        single clock, rising edge
//  rst     in   1        synchronous, active-high reset
//  in      in   CH       raw asynchronous inputs; bit i = channel i
//  mode    in   2*CH     per-channel mode, bits [2i+1:2i]: 00 off, 01 rise, 10 fall, 11 both
//  clr     in   CH       per-channel clear of evt and cnt (level, sampled each clk)
//  lvl     out  CH       filtered, synchronized level of each channel
//  pulse   out  CH       one-cycle strobe per detected (enabled) edge, registered
//  evt     out  CH       sticky event flags
//  cnt     out  CH*CNT_W saturating event counts; channel i at [i*CNT_W +: CNT_W]
//  irq     out  1        OR of all evt bits (combinational from evt registers)
// BEHAVIOUR
//  - Reset (rst high at a clk edge): sync chain, filtered level, prev level, pulse, evt, cnt all 0;
//    irq 0, lvl 0. A rise on the same edge as reset release is not sampled.
//  - Sync: sync[0] <= in; sync[j] <= sync[j-1]. Raw level s = sync[SYNC_STAGES-1].
//  - Without debounce: filtered level f = s (wire). prev <= f each cycle.
//  - Detect: rise = f & ~prev; fall = ~f & prev; hit = (mode[0] & rise) | (mode[1] & fall).
//    pulse <= hit. If in changes and is first sampled at edge k, pulse is high from edge
//    k+SYNC_STAGES to edge k+SYNC_STAGES+1 (no debounce).
//  - prev tracks f in every mode, including 00, so enabling a channel never creates a
//    spurious edge. Mode changes take effect at the next clk edge.
//  - Input held high through reset release produces a rise pulse, because prev resets to 0.
//  - Glitch shorter than one clk period may be missed; this is not an error.
//  - evt: set when pulse is set, cleared by clr; pulse and clr in the same cycle -> evt stays 1.
//  - cnt: +1 on each pulse, saturates at 2^CNT_W-1, never wraps. clr -> 0.
//    clr and pulse in the same cycle -> cnt = 1.
//  - clr held high: evt/cnt remain cleared except for the set-wins cases above.
//  - rst asserted mid-operation: all state returns to reset values at that edge; a partial
//    debounce count is discarded.
// CONFIGURATION
//  Macro EDGE_DEBOUNCE_EN:
//   defined     -> per-channel counter, $clog2(DB_CYCLES+1) bits.
//                  - s != f: counter increments.
//                  - counter reaches DB_CYCLES: f <= s and counter clears.
//                  - s == f: counter clears.
//                  Added latency = DB_CYCLES cycles. f is registered.
//   not defined -> f = s. No counter logic is generated. DB_CYCLES is ignored.
// STRUCTURE
//  Package edge_det_pkg:
//   - localparams MODE_OFF=2'b00, MODE_RISE=2'b01, MODE_FALL=2'b10, MODE_BOTH=2'b11.
//   - function sat_inc(cnt) for the saturating increment.
//  Sub-module edge_det_channel:
//   - one channel: sync chain, debounce, detect, evt, cnt.
//   - parameters SYNC_STAGES, DB_CYCLES, CNT_W.
//  Top level instantiates edge_det_channel CH times in a generate loop and ORs evt into irq.
// TESTING
//  1. Reset values: rst=1 for 3 cycles with in=0 -> lvl/pulse/evt/irq=0, cnt=0 on every channel.
//  2. Channel 0, mode 01, in[0] 0->1 at edge k (no debounce, SYNC_STAGES=2):
//     - pulse[0]=1 for exactly the cycle after edge k+2; evt[0]=1; cnt[0]=1; irq=1.
//     - in[0] 1->0 afterwards gives no pulse.
//  3. Channel 1, mode 11, toggle in[1] 5 times: 5 single-cycle pulses, cnt[1]=5.
//     Then mode 10, one rise + one fall: cnt[1]=6.
//  4. CNT_W=2, 5 rises on channel 2: cnt saturates at 3.
//     Assert clr[2] in the same cycle as a pulse: evt[2]=1, cnt[2]=1.
//  5. Mode 00 while in toggles: no pulse, evt stays 0, lvl still follows the input.
//     Switch to 01 while in=1: no pulse until the next real rise.
//  6. EDGE_DEBOUNCE_EN, DB_CYCLES=16:
//     - 10-cycle high glitch -> no pulse, lvl stays 0.
//     - 20-cycle high -> lvl rises after 16 stable cycles, one pulse.
//     - rst during the count -> counter cleared, lvl=0.

Source files
------------

// File: rtl/edge_det_pkg.sv
// Shared mode encodings and the saturating increment
// used by the edge-detector channels.
package edge_det_pkg;

    localparam logic [1:0] MODE_OFF  = 2'b00;
    localparam logic [1:0] MODE_RISE = 2'b01;
    localparam logic [1:0] MODE_FALL = 2'b10;
    localparam logic [1:0] MODE_BOTH = 2'b11;

    // w is the live counter width; the result sticks at 2^w-1
    function automatic logic [31:0] sat_inc(
        input logic [31:0] v,
        input int unsigned w
    );
        logic [31:0] mx;
        mx = (w >= 32) ? 32'hffff_ffff
                       : ((32'd1 << w) - 32'd1);
        return (v >= mx) ? mx : v + 32'd1;
    endfunction

endpackage

// File: rtl/edge_det_channel.sv
// One edge-detector channel: sync, optional debounce, detect, flag, count.
// Debounce filter is built only when EDGE_DEBOUNCE_EN is defined.
module edge_det_channel
    import edge_det_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int DB_CYCLES   = 16,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in,
    input  logic [1:0]       mode,
    input  logic             clr,
    output logic             lvl,
    output logic             pulse,
    output logic             evt,
    output logic [CNT_W-1:0] cnt
);

    if (SYNC_STAGES < 2 || DB_CYCLES < 1 ||
        CNT_W < 1 || CNT_W > 32) begin : g_bad_param
        $error("edge_det_channel: bad parameter");
    end

    logic [SYNC_STAGES-1:0] sync;
    logic s;
    logic f;
    logic prev;
    logic rise;
    logic fall;
    logic hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync <= '0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], in};
        end
    end

    assign s = sync[SYNC_STAGES-1];

`ifdef EDGE_DEBOUNCE_EN
    localparam int DW = $clog2(DB_CYCLES + 1);
    localparam logic [DW-1:0] DB_LAST = DW'(DB_CYCLES - 1);

    logic [DW-1:0] db;

    // f only moves after s has disagreed with it for DB_CYCLES cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            db <= '0;
            f  <= 1'b0;
        end else if (s == f) begin
            db <= '0;
        end else if (db == DB_LAST) begin
            db <= '0;
            f  <= s;
        end else begin
            db <= db + DW'(1);
        end
    end
`else
    assign f = s;
`endif

    assign rise = f & ~prev;
    assign fall = ~f & prev;

    always_comb begin
        hit = 1'b0;
        unique case (mode)
            MODE_OFF:  hit = 1'b0;
            MODE_RISE: hit = rise;
            MODE_FALL: hit = fall;
            MODE_BOTH: hit = rise | fall;
            default:   hit = 1'b0;
        endcase
    end

    // a new hit wins over a simultaneous clear
    always_ff @(posedge clk) begin
        if (rst) begin
            prev  <= 1'b0;
            pulse <= 1'b0;
            evt   <= 1'b0;
            cnt   <= '0;
        end else begin
            prev  <= f;
            pulse <= hit;
            evt   <= hit | (evt & ~clr);
            if (clr) begin
                cnt <= hit ? CNT_W'(1) : '0;
            end else if (hit) begin
                cnt <= CNT_W'(sat_inc(32'(cnt), CNT_W));
            end
        end
    end

    assign lvl = f;

endmodule

// File: rtl/multi_edge_detector.sv
// N-channel edge detector with sticky flags, counters and a shared irq.
// Define EDGE_DEBOUNCE_EN to add a per-channel debounce filter.
module multi_edge_detector
    import edge_det_pkg::*;
#(
    parameter int CH          = 4,
    parameter int SYNC_STAGES = 2,
    parameter int DB_CYCLES   = 16,
    parameter int CNT_W       = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CH-1:0]       in,
    input  logic [2*CH-1:0]     mode,
    input  logic [CH-1:0]       clr,
    output logic [CH-1:0]       lvl,
    output logic [CH-1:0]       pulse,
    output logic [CH-1:0]       evt,
    output logic [CH*CNT_W-1:0] cnt,
    output logic                irq
);

    for (genvar i = 0; i < CH; i++) begin : g_ch
        edge_det_channel #(
            .SYNC_STAGES(SYNC_STAGES),
            .DB_CYCLES  (DB_CYCLES),
            .CNT_W      (CNT_W)
        ) u_ch (
            .clk  (clk),
            .rst  (rst),
            .in   (in[i]),
            .mode (mode[2*i +: 2]),
            .clr  (clr[i]),
            .lvl  (lvl[i]),
            .pulse(pulse[i]),
            .evt  (evt[i]),
            .cnt  (cnt[i*CNT_W +: CNT_W])
        );
    end

    assign irq = |evt;

endmodule

// File: tb/tb_multi_edge_detector.sv
// Directed bench for multi_edge_detector; a second instance
// with 2-bit counters covers saturation.
module tb_multi_edge_detector;

    localparam int CH = 4;
    localparam int SS = 2;
    localparam int DB = 16;
    localparam int CW = 8;
`ifdef EDGE_DEBOUNCE_EN
    localparam int DL = SS + DB;
`else
    localparam int DL = SS;
`endif

    logic clk = 1'b0;
    logic rst;
    logic [CH-1:0] in;
    logic [2*CH-1:0] mode;
    logic [CH-1:0] clr;

    logic [CH-1:0] lvl, pulse, evt;
    logic [CH*CW-1:0] cnt;
    logic irq;

    logic [CH-1:0] s_lvl, s_pulse, s_evt;
    logic [CH*2-1:0] s_cnt;
    logic s_irq;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    multi_edge_detector #(
        .CH(CH), .SYNC_STAGES(SS),
        .DB_CYCLES(DB), .CNT_W(CW)
    ) u_dut (
        .clk(clk), .rst(rst), .in(in),
        .mode(mode), .clr(clr), .lvl(lvl),
        .pulse(pulse), .evt(evt), .cnt(cnt),
        .irq(irq)
    );

    multi_edge_detector #(
        .CH(CH), .SYNC_STAGES(SS),
        .DB_CYCLES(DB), .CNT_W(2)
    ) u_sat (
        .clk(clk), .rst(rst), .in(in),
        .mode(mode), .clr(clr), .lvl(s_lvl),
        .pulse(s_pulse), .evt(s_evt), .cnt(s_cnt),
        .irq(s_irq)
    );

    task automatic chk(
        input string tag,
        input logic [31:0] obs,
        input logic [31:0] exp
    );
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h",
                   tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] c8(input int ch);
        return cnt[ch*CW +: CW];
    endfunction

    // drive one level change and check the strobe window
    task automatic edge_chk(
        input int ch,
        input logic v,
        input logic exp_p
    );
        in[ch] = v;
        cyc(DL);
        chk("pulse_early", 32'(pulse[ch]), 0);
        cyc(1);
        chk("pulse_hit", 32'(pulse[ch]), 32'(exp_p));
        cyc(1);
        chk("pulse_len", 32'(pulse[ch]), 0);
        cyc(2);
    endtask

    initial begin
        rst  = 1'b1;
        in   = '0;
        mode = '0;
        clr  = '0;

        // reset
        cyc(3);
        chk("rst_lvl", 32'(lvl), 0);
        chk("rst_pulse", 32'(pulse), 0);
        chk("rst_evt", 32'(evt), 0);
        chk("rst_irq", 32'(irq), 0);
        chk("rst_cnt", cnt, 0);
        chk("rst_scnt", 32'(s_cnt), 0);
        rst = 1'b0;

        // channel 0 rise only
        mode[1:0] = 2'b01;
        cyc(2);
        in[0] = 1'b1;
        cyc(DL);
        chk("c0_lvl", 32'(lvl[0]), 1);
        chk("c0_pre", 32'(pulse), 0);
        cyc(1);
        chk("c0_pulse", 32'(pulse), 32'h1);
        chk("c0_evt", 32'(evt), 32'h1);
        chk("c0_cnt", 32'(c8(0)), 1);
        chk("c0_irq", 32'(irq), 1);
        cyc(1);
        chk("c0_post", 32'(pulse), 0);
        in[0] = 1'b0;
        cyc(DL + 1);
        chk("c0_fall", 32'(pulse), 0);
        chk("c0_lvl0", 32'(lvl[0]), 0);
        chk("c0_cnt1", 32'(c8(0)), 1);
        clr[0] = 1'b1;
        cyc(1);
        clr[0] = 1'b0;
        chk("c0_clr_evt", 32'(evt), 0);
        chk("c0_clr_cnt", 32'(c8(0)), 0);
        chk("c0_clr_irq", 32'(irq), 0);

        // channel 1 both edges, then fall only
        mode[3:2] = 2'b11;
        for (int i = 0; i < 5; i++)
            edge_chk(1, ~in[1], 1'b1);
        chk("c1_cnt5", 32'(c8(1)), 5);
        mode[3:2] = 2'b10;
        cyc(1);
        edge_chk(1, 1'b0, 1'b1);
        edge_chk(1, 1'b1, 1'b0);
        chk("c1_cnt6", 32'(c8(1)), 6);

        // channel 2 saturation and clear/pulse collision
        mode[5:4] = 2'b01;
        cyc(1);
        for (int i = 0; i < 5; i++) begin
            edge_chk(2, 1'b1, 1'b1);
            edge_chk(2, 1'b0, 1'b0);
        end
        chk("c2_cnt5", 32'(c8(2)), 5);
        chk("c2_sat3", 32'(s_cnt[5:4]), 3);
        in[2] = 1'b1;
        cyc(DL);
        clr[2] = 1'b1;
        cyc(1);
        clr[2] = 1'b0;
        chk("c2_clr_p", 32'(pulse[2]), 1);
        chk("c2_clr_evt", 32'(s_evt[2]), 1);
        chk("c2_clr_scnt", 32'(s_cnt[5:4]), 1);
        chk("c2_clr_cnt", 32'(c8(2)), 1);
        in[2] = 1'b0;
        cyc(DL + 3);

        // channel 3 off, then enable while high
        in[3] = 1'b1;
        cyc(DL);
        chk("c3_lvl1", 32'(lvl[3]), 1);
        cyc(1);
        chk("c3_off_p", 32'(pulse[3]), 0);
        chk("c3_off_e", 32'(evt[3]), 0);
        in[3] = 1'b0;
        cyc(DL + 1);
        chk("c3_lvl0", 32'(lvl[3]), 0);
        chk("c3_off_p2", 32'(pulse[3]), 0);
        in[3] = 1'b1;
        cyc(DL + 3);
        mode[7:6] = 2'b01;
        for (int i = 0; i < 4; i++) begin
            cyc(1);
            chk("c3_en_p", 32'(pulse[3]), 0);
        end
        chk("c3_en_e", 32'(evt[3]), 0);
        edge_chk(3, 1'b0, 1'b0);
        edge_chk(3, 1'b1, 1'b1);
        chk("c3_evt", 32'(evt[3]), 1);

`ifdef EDGE_DEBOUNCE_EN
        // debounce: glitch, long pulse, reset mid-count
        clr[0] = 1'b1;
        cyc(1);
        clr[0] = 1'b0;
        in[0] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cyc(1);
            chk("db_gl_lvl", 32'(lvl[0]), 0);
        end
        in[0] = 1'b0;
        for (int i = 0; i < 25; i++) begin
            cyc(1);
            chk("db_gl_lvl", 32'(lvl[0]), 0);
            chk("db_gl_p", 32'(pulse[0]), 0);
        end
        chk("db_gl_evt", 32'(evt[0]), 0);
        in[0] = 1'b1;
        cyc(DL - 1);
        chk("db_lvl_pre", 32'(lvl[0]), 0);
        cyc(1);
        chk("db_lvl", 32'(lvl[0]), 1);
        cyc(1);
        chk("db_pulse", 32'(pulse[0]), 1);
        cyc(1);
        chk("db_pulse_len", 32'(pulse[0]), 0);
        in[0] = 1'b0;
        cyc(40);
        chk("db_cnt", 32'(c8(0)), 1);
        chk("db_lvl_low", 32'(lvl[0]), 0);
        in[0] = 1'b1;
        cyc(8);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        chk("db_rst_lvl", 32'(lvl[0]), 0);
        chk("db_rst_cnt", 32'(c8(0)), 0);
        chk("db_rst_evt", 32'(evt), 0);
        cyc(DL - 1);
        chk("db_rst_pre", 32'(lvl[0]), 0);
        cyc(1);
        chk("db_rst_lvl1", 32'(lvl[0]), 1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
